ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter. The other direction of the existing ps2 keyboard receiver.
- Sends one command byte per request to the keyboard, e.g. 0xED for set-LEDs or 0xFF for reset, using the PS/2 inhibit/request-to-send sequence.
- Drives the open-drain PS2_CLK/PS2_DAT pads through output-enable pins and reports the device ACK.
- Sits beside ps2 in main. Its rx_inhibit tells the receiver to ignore line activity while a transmission is in progress.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_line_filter.sv | 56 +++++
 rtl/ps2_host_tx.sv | 186 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-side blocks: FSM states, frame
// geometry and default 50 MHz timing constants.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_state_e;

  // start + 8 data + parity + stop; the device ACK arrives on the 11th fall
  localparam int FRAME_BITS = 11;
  localparam int ACK_FALL   = 11;

  localparam int DEF_INHIBIT_CYCLES = 6000;    // 120 us
  localparam int DEF_REQ_CYCLES     = 50;
  localparam int DEF_TIMEOUT_CYCLES = 750000;  // 15 ms
  localparam int DEF_FILTER_LEN     = 8;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions one raw PS/2 pad: 2-FF synchroniser, stable-run filter and a
// one-cycle pulse on every filtered 1->0 transition. Idle level is 1.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic pad_i,
  output logic level_o,
  output logic fall_o
);

  localparam int            CW       = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          fall_q;
  logic [CW-1:0] cnt_q;

  // Bring the asynchronous pad into the clock domain
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= pad_i;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
      fall_q  <= 1'b0;
    end else begin
      fall_q <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
        fall_q  <= ~sync2_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter. Performs the inhibit /
// request-to-send handshake, shifts one byte out on device clock falls,
// collects the device ACK and reports done/ack_err/timeout.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int REQ_CYCLES     = DEF_REQ_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       done,
  output logic       ack_err,
  output logic       timeout,
  output logic       rx_inhibit
);

  localparam int PHASE_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int PW        = $clog2(PHASE_MAX + 1);
  localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PW-1:0] INH_LAST   = PW'(INHIBIT_CYCLES - 1);
  localparam logic [PW-1:0] REQ_LAST   = PW'(REQ_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  // bit counter value just before the fall that puts the stop bit out
  localparam logic [3:0]    LAST_SHIFT = 4'(ACK_FALL - 2);

  ps2_state_e    state_q;
  logic [9:0]    shreg_q;
  logic [PW-1:0] phase_cnt_q;
  logic [TW-1:0] tmo_cnt_q;
  logic [3:0]    bit_cnt_q;
  logic          clk_oe_q;
  logic          dat_oe_q;
  logic          done_q;
  logic          ack_err_q;
  logic          timeout_q;
  logic          rx_inh_q;
  logic          tx_ready_q;

  logic clk_level;
  logic clk_fall;
  logic dat_level;
  logic unused_dat_fall;
  logic frame_active;
  logic tmo_expired;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clock   (clock),
    .reset   (reset),
    .pad_i   (ps2_clk_in),
    .level_o (clk_level),
    .fall_o  (clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .clock   (clock),
    .reset   (reset),
    .pad_i   (ps2_dat_in),
    .level_o (dat_level),
    .fall_o  (unused_dat_fall)
  );

  // The timeout window spans everything after the host releases CLK
  assign frame_active = (state_q == SHIFT) || (state_q == ACK) || (state_q == WAIT_IDLE);
  assign tmo_expired  = frame_active && (tmo_cnt_q == TMO_LAST);

  // Transmit FSM with all outputs registered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      phase_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      clk_oe_q    <= 1'b0;
      dat_oe_q    <= 1'b0;
      done_q      <= 1'b0;
      ack_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
      rx_inh_q    <= 1'b0;
      tx_ready_q  <= 1'b1;
    end else begin
      done_q <= 1'b0;
      if (tmo_expired) begin
        // abort beats any fall_clk arriving on the same cycle
        clk_oe_q   <= 1'b0;
        dat_oe_q   <= 1'b0;
        done_q     <= 1'b1;
        timeout_q  <= 1'b1;
        ack_err_q  <= 1'b1;
        rx_inh_q   <= 1'b0;
        tx_ready_q <= 1'b1;
        state_q    <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (tx_valid && tx_ready_q) begin
              shreg_q     <= {1'b1, odd_parity(tx_data), tx_data};
              ack_err_q   <= 1'b0;
              timeout_q   <= 1'b0;
              phase_cnt_q <= '0;
              clk_oe_q    <= 1'b1;
              dat_oe_q    <= 1'b0;
              rx_inh_q    <= 1'b1;
              tx_ready_q  <= 1'b0;
              state_q     <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (phase_cnt_q == INH_LAST) begin
              phase_cnt_q <= '0;
              dat_oe_q    <= 1'b1;   // start bit
              state_q     <= REQ;
            end else begin
              phase_cnt_q <= phase_cnt_q + PW'(1);
            end
          end
          REQ: begin
            if (phase_cnt_q == REQ_LAST) begin
              clk_oe_q  <= 1'b0;
              bit_cnt_q <= '0;
              tmo_cnt_q <= '0;
              state_q   <= SHIFT;
            end else begin
              phase_cnt_q <= phase_cnt_q + PW'(1);
            end
          end
          SHIFT: begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
            if (clk_fall) begin
              dat_oe_q  <= ~shreg_q[0];
              shreg_q   <= {1'b0, shreg_q[9:1]};
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == LAST_SHIFT) begin
                state_q <= ACK;
              end
            end
          end
          ACK: begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
            if (clk_fall) begin
              ack_err_q <= dat_level;   // device pulls DAT low to acknowledge
              bit_cnt_q <= bit_cnt_q + 4'd1;
              state_q   <= WAIT_IDLE;
            end
          end
          WAIT_IDLE: begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
            if (clk_level && dat_level) begin
              done_q     <= 1'b1;
              rx_inh_q   <= 1'b0;
              tx_ready_q <= 1'b1;
              state_q    <= IDLE;
            end
          end
          default: begin
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            rx_inh_q   <= 1'b0;
            tx_ready_q <= 1'b1;
            state_q    <= IDLE;
          end
        endcase
      end
    end
  end

  assign tx_ready   = tx_ready_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign done       = done_q;
  assign ack_err    = ack_err_q;
  assign timeout    = timeout_q;
  assign rx_inhibit = rx_inh_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural keyboard model,
// a per-cycle compare process against a timing model, and directed plus
// randomised command frames.
module tb_ps2_host_tx;

  localparam int INH = 1000;
  localparam int REQ = 50;
  localparam int TMO = 3000;
  localparam int FL  = 8;

  localparam int M_ACK    = 0;
  localparam int M_NOACK  = 1;
  localparam int M_NOCLK  = 2;
  localparam int M_GLITCH = 3;
  localparam int M_RESET  = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       done;
  logic       ack_err;
  logic       timeout;
  logic       rx_inhibit;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       bus_clk;
  logic       bus_dat;

  assign bus_clk = ~(ps2_clk_oe | dev_clk_low);
  assign bus_dat = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .REQ_CYCLES     (REQ),
    .TIMEOUT_CYCLES (TMO),
    .FILTER_LEN     (FL)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_in (bus_clk),
    .ps2_dat_in (bus_dat),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .done       (done),
    .ack_err    (ack_err),
    .timeout    (timeout),
    .rx_inhibit (rx_inhibit)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model state: acceptance events from the stimulus, expected status flags
  int acc_cnt   = 0;
  int acc_seen  = 0;
  int acc_cyc   = 0;
  bit m_busy    = 1'b0;
  bit m_ack_exp = 1'b0;
  bit m_tmo_exp = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected frame from the protocol rules: data LSB first, odd parity, stop=1
  function automatic logic [9:0] model_frame(input logic [7:0] b);
    logic [9:0] f;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i] = b[i];
      if (b[i]) ones++;
    end
    f[8] = ((ones % 2) == 0);
    f[9] = 1'b1;
    return f;
  endfunction

  // Per-cycle comparison against the timing model
  always @(negedge clock) begin
    int k;
    if (reset) begin
      m_busy   = 1'b0;
      acc_seen = acc_cnt;
    end else begin
      if (acc_seen != acc_cnt) begin
        acc_seen = acc_cnt;
        m_busy   = 1'b1;
      end
      k = cyc - acc_cyc;
      if (done) begin
        check("done_only_when_busy", 32'(m_busy), 32'd1);
        m_busy = 1'b0;
      end else if (m_busy) begin
        check("busy_tx_ready", 32'(tx_ready), 32'd0);
        check("busy_rx_inhibit", 32'(rx_inhibit), 32'd1);
        check("busy_timeout_flag", 32'(timeout), 32'd0);
        if (k < INH)
          check("inhibit_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd2);
        else if (k < INH + REQ)
          check("req_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd3);
        else
          check("clk_released", 32'(ps2_clk_oe), 32'd0);
      end else begin
        check("idle_tx_ready", 32'(tx_ready), 32'd1);
        check("idle_rx_inhibit", 32'(rx_inhibit), 32'd0);
        check("idle_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
        check("idle_ack_err", 32'(ack_err), 32'(m_ack_exp));
        check("idle_timeout", 32'(timeout), 32'(m_tmo_exp));
      end
    end
  end

  // One host transaction with a keyboard model behaving according to mode
  task automatic run_tx(input logic [7:0] b, input int mode, input int half,
                        output logic [9:0] got);
    bit seen;
    int dk;
    got = '0;
    @(negedge clock);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clock);
    #1;
    tx_valid  = 1'b0;
    acc_cyc   = cyc;
    acc_cnt   = acc_cnt + 1;
    m_ack_exp = (mode == M_NOACK) || (mode == M_NOCLK);
    m_tmo_exp = (mode == M_NOCLK);
    if (mode == M_GLITCH) begin
      // a second request while busy must be dropped
      repeat (100) @(negedge clock);
      tx_data  = 8'h55;
      tx_valid = 1'b1;
      @(negedge clock);
      tx_valid = 1'b0;
      tx_data  = b;
    end
    while ((cyc - acc_cyc) < INH + REQ + 2) @(negedge clock);
    check("start_bit", 32'(bus_dat), 32'd0);
    if (mode != M_NOCLK) begin
      repeat (half) @(negedge clock);
      for (int i = 1; i <= 11; i++) begin
        dev_clk_low = 1'b1;
        if (mode == M_RESET && i == 4) begin
          repeat (half / 2) @(negedge clock);
          #3 reset = 1'b1;
          #1 check("async_release", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
          m_ack_exp   = 1'b0;
          m_tmo_exp   = 1'b0;
          dev_clk_low = 1'b0;
          dev_dat_low = 1'b0;
          repeat (3) @(negedge clock);
          #3 reset = 1'b0;
          @(negedge clock);
          check("ready_after_reset", 32'(tx_ready), 32'd1);
          return;
        end
        repeat (half) @(negedge clock);
        dev_clk_low = 1'b0;
        if (i <= 10) got[i-1] = bus_dat;
        if (i == 10 && mode != M_NOACK) dev_dat_low = 1'b1;
        if (i == 11) begin
          dev_dat_low = 1'b0;
          break;
        end
        if (mode == M_GLITCH && i == 4) begin
          repeat (half / 2) @(negedge clock);
          dev_clk_low = 1'b1;
          repeat (3) @(negedge clock);
          dev_clk_low = 1'b0;
          repeat (half - half / 2 - 3) @(negedge clock);
        end else begin
          repeat (half) @(negedge clock);
        end
      end
    end
    seen = 1'b0;
    dk   = 0;
    for (int n = 0; n < ((mode == M_NOCLK) ? TMO + 20 : 200) && !seen; n++) begin
      @(negedge clock);
      if (done) begin
        seen = 1'b1;
        dk   = cyc - acc_cyc;
        check("done_ack_err", 32'(ack_err), 32'(m_ack_exp));
        check("done_timeout", 32'(timeout), 32'(m_tmo_exp));
        check("done_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    if (mode == M_NOCLK) check("timeout_latency", 32'(dk), 32'(INH + REQ + TMO));
    @(negedge clock);
    check("ready_after_done", 32'(tx_ready), 32'd1);
  endtask

  initial begin
    logic [9:0] got;
    logic [7:0] b;
    int         mode;
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (5) @(negedge clock);
    check("reset_outputs", 32'({ps2_clk_oe, ps2_dat_oe, done, ack_err, timeout, rx_inhibit}), 32'd0);
    #3 reset = 1'b0;
    @(negedge clock);
    check("reset_tx_ready", 32'(tx_ready), 32'd1);

    // model pins
    check("model_ED", 32'(model_frame(8'hED)), 32'h3ED);
    check("model_01", 32'(model_frame(8'h01)), 32'h201);

    run_tx(8'hED, M_ACK, 40, got);
    check("frame_ED", 32'(got), 32'h3ED);
    run_tx(8'h01, M_ACK, 35, got);
    check("parity_01", 32'(got[8]), 32'd0);
    check("frame_01", 32'(got), 32'(model_frame(8'h01)));
    run_tx(8'hFF, M_ACK, 45, got);
    check("parity_FF", 32'(got[8]), 32'd1);
    check("frame_FF", 32'(got), 32'(model_frame(8'hFF)));
    run_tx(8'hA5, M_NOACK, 40, got);
    check("frame_A5", 32'(got), 32'(model_frame(8'hA5)));
    run_tx(8'h12, M_NOCLK, 40, got);
    run_tx(8'h3C, M_GLITCH, 40, got);
    check("frame_glitch", 32'(got), 32'(model_frame(8'h3C)));
    repeat (50) @(negedge clock);
    run_tx(8'h99, M_RESET, 40, got);
    run_tx(8'hF4, M_ACK, 40, got);
    check("frame_F4", 32'(got), 32'h2F4);

    for (int r = 0; r < 6; r++) begin
      b    = 8'($urandom_range(0, 255));
      mode = ($urandom_range(0, 3) == 0) ? M_NOACK : M_ACK;
      run_tx(b, mode, int'($urandom_range(30, 50)), got);
      check("frame_random", 32'(got), 32'(model_frame(b)));
    end

    repeat (20) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: actual=expired required=finished");
    $fatal(1, "watchdog");
  end

endmodule
